// File: rtl/pipe_latch.sv
// Pipeline-stage latch with valid/ready handshake, whole-stage flush, ack-cleared request bits
// and a saturating stall counter. Define PIPE_LATCH_SKID_EN for the two-entry skid buffer.
module pipe_latch #(
    parameter int DATA_W = 128,
    parameter int REQ_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [REQ_W-1:0]  in_req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [REQ_W-1:0]  out_req,
    input  logic              flush,
    input  logic              req_ack,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [REQ_W-1:0]  m_req_q, m_req_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              accept;
    logic              m_free;

`ifdef PIPE_LATCH_SKID_EN
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [REQ_W-1:0]  s_req_q, s_req_d;

    // Ready depends only on a flop, so no combinational path from out_ready.
    assign in_ready = !s_valid_q;
`else
    assign in_ready = !m_valid_q | out_ready;
`endif

    assign accept    = in_valid & in_ready;
    assign m_free    = !m_valid_q | out_ready;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    assign out_req   = m_req_q & {REQ_W{m_valid_q}};
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_req_d   = m_req_q;
`ifdef PIPE_LATCH_SKID_EN
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_req_d   = s_req_q;
`endif
        if (flush) begin
            // Data fields are left alone; only valid and req bits are authoritative.
            m_valid_d = 1'b0;
            m_req_d   = '0;
`ifdef PIPE_LATCH_SKID_EN
            s_valid_d = 1'b0;
            s_req_d   = '0;
`endif
        end else if (m_free) begin
`ifdef PIPE_LATCH_SKID_EN
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data_q;
                m_req_d   = s_req_q;
                s_valid_d = 1'b0;
            end else
`endif
            if (accept) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
                m_req_d   = in_req;
            end else begin
                m_valid_d = 1'b0;
            end
        end else begin
`ifdef PIPE_LATCH_SKID_EN
            if (accept) begin
                s_valid_d = 1'b1;
                s_data_d  = in_data;
                s_req_d   = in_req;
            end
`endif
            // The acknowledge only applies to an entry that stays in M.
            if (req_ack) begin
                m_req_d = '0;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_req_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_req_q     <= m_req_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef PIPE_LATCH_SKID_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_req_q   <= '0;
        end else begin
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            s_req_q   <= s_req_d;
        end
    end
`endif

endmodule
